// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-way channel select into a 2-entry (head + skid) output FIFO.
// Ports:
//   clk, rst_n         clock, async active-low reset
//   in_data, sel       packed N x WIDTH channels and channel index
//   in_valid/in_ready  upstream handshake
//   out_data/out_valid/out_ready  downstream handshake (out_data = head)
//   flush, err_clr     sync discard of buffered beats, sync clear of sel_err
//   sel_err, occ       sticky out-of-range-sel flag, buffered beat count
module mux_n_pipe #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SEL_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]   sel,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    input  logic               flush,
    input  logic               err_clr,
    output logic               sel_err,
    output logic [1:0]         occ
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [31:0] N_U = 32'(N);

    state_t             r_state;
    state_t             w_state_nx;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   r_skid;
    logic [WIDTH-1:0]   w_head_nx;
    logic [WIDTH-1:0]   w_skid_nx;
    logic [WIDTH-1:0]   w_sel_data;
    logic [31:0]        w_sel_ext;
    logic               w_sel_oor;
    logic               w_accept;
    logic               w_fire;
    logic               r_sel_err;

    assign w_sel_ext = 32'(sel);
    assign w_sel_oor = (w_sel_ext >= N_U);

    // Out-of-range select matches no channel and yields zero.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (w_sel_ext == 32'(k)) begin
                w_sel_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // rst_n gating keeps in_ready low throughout reset.
    assign in_ready  = rst_n && (r_state != ST_TWO) && !flush;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_head;
    assign occ       = r_state;
    assign sel_err   = r_sel_err;

    assign w_accept = in_valid && in_ready;
    assign w_fire   = out_valid && out_ready;

    always_comb begin
        w_state_nx = r_state;
        w_head_nx  = r_head;
        w_skid_nx  = r_skid;
        if (flush) begin
            w_state_nx = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nx = ST_ONE;
                        w_head_nx  = w_sel_data;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_fire) begin
                        w_head_nx = w_sel_data;
                    end else if (w_accept) begin
                        w_state_nx = ST_TWO;
                        w_skid_nx  = w_sel_data;
                    end else if (w_fire) begin
                        w_state_nx = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_fire) begin
                        w_state_nx = ST_ONE;
                        w_head_nx  = r_skid;
                    end
                end
                default: begin
                    w_state_nx = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_head  <= '0;
            r_skid  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_head  <= w_head_nx;
            r_skid  <= w_skid_nx;
        end
    end

    // Set beats clear when both happen in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_oor) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_n_pipe.sv
// tb_mux_n_pipe: randomized and directed checks of mux_n_pipe
// against a queue-based reference model (N=4, N=3, N=2 instances).
module tb_mux_n_pipe;

    localparam int W4 = 32;
    localparam int N4 = 4;
    localparam int W3 = 16;
    localparam int N3 = 3;
    localparam int W2 = 8;
    localparam int N2 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // N=4 instance
    logic [N4*W4-1:0] a_data = '0;
    logic [1:0]       a_sel = '0;
    logic             a_iv = 0, a_or = 0, a_fl = 0, a_clr = 0;
    logic             a_ir, a_ov, a_err;
    logic [W4-1:0]    a_od;
    logic [1:0]       a_occ;

    // N=3 instance
    logic [N3*W3-1:0] b_data = '0;
    logic [1:0]       b_sel = '0;
    logic             b_iv = 0, b_or = 0, b_fl = 0, b_clr = 0;
    logic             b_ir, b_ov, b_err;
    logic [W3-1:0]    b_od;
    logic [1:0]       b_occ;

    // N=2 instance
    logic [N2*W2-1:0] c_data = '0;
    logic [0:0]       c_sel = '0;
    logic             c_iv = 0, c_or = 0, c_fl = 0, c_clr = 0;
    logic             c_ir, c_ov, c_err;
    logic [W2-1:0]    c_od;
    logic [1:0]       c_occ;

    mux_n_pipe #(.WIDTH(W4), .N(N4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_data(a_data), .sel(a_sel),
        .in_valid(a_iv), .in_ready(a_ir), .out_data(a_od),
        .out_valid(a_ov), .out_ready(a_or), .flush(a_fl),
        .err_clr(a_clr), .sel_err(a_err), .occ(a_occ)
    );

    mux_n_pipe #(.WIDTH(W3), .N(N3)) u3 (
        .clk(clk), .rst_n(rst_n), .in_data(b_data), .sel(b_sel),
        .in_valid(b_iv), .in_ready(b_ir), .out_data(b_od),
        .out_valid(b_ov), .out_ready(b_or), .flush(b_fl),
        .err_clr(b_clr), .sel_err(b_err), .occ(b_occ)
    );

    mux_n_pipe #(.WIDTH(W2), .N(N2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_data(c_data), .sel(c_sel),
        .in_valid(c_iv), .in_ready(c_ir), .out_data(c_od),
        .out_valid(c_ov), .out_ready(c_or), .flush(c_fl),
        .err_clr(c_clr), .sel_err(c_err), .occ(c_occ)
    );

    // Reference model for u4: a queue of beats in acceptance order.
    logic [W4-1:0] ch4 [N4];
    logic [W4-1:0] q4 [$];

    // Snapshot (s_*) and model expectation (e_*) of the last cycle.
    logic          s_ir, s_ov, s_err;
    logic [W4-1:0] s_od;
    logic [1:0]    s_occ;
    logic          e_ir, e_ov;
    logic [W4-1:0] e_od;
    logic [1:0]    e_occ;

    task automatic drive4(input bit iv, input logic [1:0] s,
                          input bit ordy, input bit fl);
        bit acc, fire;
        @(negedge clk);
        for (int k = 0; k < N4; k++) a_data[k*W4 +: W4] = ch4[k];
        a_iv = iv; a_sel = s; a_or = ordy; a_fl = fl; a_clr = 0;
        #1;
        s_ir = a_ir; s_ov = a_ov; s_od = a_od; s_occ = a_occ;
        s_err = a_err;
        e_ir  = (q4.size() < 2) && !fl;
        e_ov  = (q4.size() != 0);
        e_occ = 2'(q4.size());
        e_od  = e_ov ? q4[0] : '0;
        acc   = iv && e_ir;
        fire  = e_ov && ordy;
        @(posedge clk);
        if (fire) void'(q4.pop_front());
        if (fl) q4.delete();
        else if (acc) q4.push_back(ch4[s]);
    endtask

    // N=3 driver: snapshot only; expectations are written in the test.
    logic [W3-1:0] ch3 [N3];
    logic          t_ov, t_err, t_ir;
    logic [W3-1:0] t_od;

    task automatic drive3(input bit iv, input logic [1:0] s,
                          input bit fl, input bit clr);
        @(negedge clk);
        for (int k = 0; k < N3; k++) b_data[k*W3 +: W3] = ch3[k];
        b_iv = iv; b_sel = s; b_or = 1; b_fl = fl; b_clr = clr;
        #1;
        t_ov = b_ov; t_od = b_od; t_err = b_err; t_ir = b_ir;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0;
        #12;
        n_tests++;
        if ({a_ir, a_ov, a_occ, a_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got ir=%b ov=%b occ=%0d err=%b required all 0",
                     a_ir, a_ov, a_occ, a_err);
        end
        n_tests++;
        if (a_od !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got %h required 0", a_od);
        end
        n_tests++;
        if ({b_ir, b_ov, b_err, c_ir, c_ov} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_others: u3/u2 not idle");
        end
        @(negedge clk);
        rst_n = 1;
        q4.delete();
        drive4(0, 0, 0, 0);
        n_tests++;
        if (s_ir !== 1'b1 || s_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got ir=%b ov=%b required 1 0",
                     s_ir, s_ov);
        end
    endtask

    task automatic test_single();
        ch4[0] = 32'h11; ch4[1] = 32'h22; ch4[2] = 32'h33; ch4[3] = 32'h44;
        drive4(1, 2, 1, 0);
        drive4(0, 0, 1, 0);
        n_tests++;
        if (s_od !== 32'h33 || s_ov !== 1'b1 || s_occ !== 2'd1) begin
            n_fail++;
            $display("FAIL single: got od=%h ov=%b occ=%0d required 33 1 1",
                     s_od, s_ov, s_occ);
        end
        drive4(0, 0, 1, 0);
        n_tests++;
        if (s_ov !== 1'b0 || s_occ !== 2'd0) begin
            n_fail++;
            $display("FAIL single_drain: got ov=%b occ=%0d required 0 0",
                     s_ov, s_occ);
        end
    endtask

    task automatic test_back_to_back();
        logic [W4-1:0] want [4];
        want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33; want[3] = 32'h44;
        for (int i = 0; i < 5; i++) begin
            drive4(i < 4, 2'(i), 1, 0);
            if (i < 4) begin
                n_tests++;
                if (s_ir !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_ready[%0d]: got %b required 1", i, s_ir);
                end
            end
            if (i > 0) begin
                n_tests++;
                if (s_od !== want[i-1] || s_ov !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_data[%0d]: got %h/%b required %h/1",
                             i, s_od, s_ov, want[i-1]);
                end
            end
        end
        drive4(0, 0, 1, 0);
    endtask

    task automatic test_backpressure();
        ch4[0] = 32'hAAAA_0001; ch4[1] = 32'hBBBB_0002;
        drive4(1, 0, 0, 0);
        drive4(1, 1, 0, 0);
        drive4(0, 0, 0, 0);
        n_tests++;
        if (s_occ !== 2'd2 || s_ir !== 1'b0 || s_od !== 32'hAAAA_0001) begin
            n_fail++;
            $display("FAIL bp_full: got occ=%0d ir=%b od=%h required 2 0 AAAA0001",
                     s_occ, s_ir, s_od);
        end
        drive4(1, 2, 0, 0);
        n_tests++;
        if (s_od !== 32'hAAAA_0001 || s_occ !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_hold: got od=%h occ=%0d required AAAA0001 2",
                     s_od, s_occ);
        end
        drive4(0, 0, 1, 0);
        drive4(0, 0, 1, 0);
        n_tests++;
        if (s_od !== 32'hBBBB_0002 || s_occ !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_second: got od=%h occ=%0d required BBBB0002 1",
                     s_od, s_occ);
        end
        drive4(0, 0, 1, 0);
        n_tests++;
        if (s_occ !== 2'd0 || s_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_empty: got occ=%0d ov=%b required 0 0", s_occ, s_ov);
        end
    endtask

    task automatic test_flush();
        ch4[0] = 32'h1234_5678; ch4[3] = 32'h8765_4321;
        drive4(1, 0, 0, 0);
        drive4(1, 3, 0, 0);
        drive4(1, 0, 0, 1);
        n_tests++;
        if (s_ir !== 1'b0 || s_occ !== 2'd2) begin
            n_fail++;
            $display("FAIL flush_cycle: got ir=%b occ=%0d required 0 2", s_ir, s_occ);
        end
        drive4(0, 0, 0, 0);
        n_tests++;
        if (s_occ !== 2'd0 || s_ov !== 1'b0 || s_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_after: got occ=%0d ov=%b ir=%b required 0 0 1",
                     s_occ, s_ov, s_ir);
        end
    endtask

    task automatic test_random();
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N4; k++) ch4[k] = $urandom;
            drive4($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                   $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            n_tests++;
            if (s_ir !== e_ir || s_ov !== e_ov || s_occ !== e_occ ||
                (e_ov && s_od !== e_od) || s_err !== 1'b0) begin
                n_fail++;
                if (errs++ < 10)
                    $display("FAIL random[%0d]: got ir=%b ov=%b occ=%0d od=%h required ir=%b ov=%b occ=%0d od=%h",
                             i, s_ir, s_ov, s_occ, s_od, e_ir, e_ov, e_occ, e_od);
            end
        end
        for (int i = 0; i < 3; i++) drive4(0, 0, 1, 0);
    endtask

    task automatic test_sel_err();
        ch3[0] = 16'h1111; ch3[1] = 16'h2222; ch3[2] = 16'h3333;
        drive3(1, 3, 0, 0);
        drive3(0, 0, 0, 0);
        n_tests++;
        if (t_od !== 16'h0 || t_ov !== 1'b1 || t_err !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_zero: got od=%h ov=%b err=%b required 0 1 1",
                     t_od, t_ov, t_err);
        end
        drive3(1, 1, 0, 0);
        drive3(0, 0, 0, 1);
        n_tests++;
        if (t_od !== 16'h2222 || t_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_sticky: got od=%h err=%b required 2222 1", t_od, t_err);
        end
        drive3(0, 0, 0, 0);
        n_tests++;
        if (t_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_clr: got %b required 0", t_err);
        end
        drive3(1, 3, 0, 0);
        drive3(1, 3, 0, 1);
        drive3(0, 0, 0, 0);
        n_tests++;
        if (t_err !== 1'b1 || t_od !== 16'h0) begin
            n_fail++;
            $display("FAIL err_set_wins: got err=%b od=%h required 1 0", t_err, t_od);
        end
        drive3(0, 0, 1, 0);
        drive3(0, 0, 0, 0);
        n_tests++;
        if (t_err !== 1'b1 || t_ov !== 1'b0) begin
            n_fail++;
            $display("FAIL err_flush: got err=%b ov=%b required 1 0", t_err, t_ov);
        end
    endtask

    task automatic test_async_reset();
        ch4[0] = 32'hDEAD_0000; ch4[1] = 32'hBEEF_0000;
        drive4(1, 0, 0, 0);
        drive4(1, 1, 0, 0);
        @(negedge clk);
        a_iv = 0; a_or = 0;
        #2;
        rst_n = 0;
        #1;
        n_tests++;
        if (a_ov !== 1'b0 || a_occ !== 2'd0 || a_ir !== 1'b0 || a_od !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got ov=%b occ=%0d ir=%b od=%h required 0 0 0 0",
                     a_ov, a_occ, a_ir, a_od);
        end
        n_tests++;
        if (b_err !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_err: got %b required 0", b_err);
        end
        @(negedge clk);
        rst_n = 1;
        q4.delete();
        drive4(0, 0, 1, 0);
        drive4(0, 0, 1, 0);
        n_tests++;
        if (s_ov !== 1'b0 || s_occ !== 2'd0 || s_ir !== 1'b1) begin
            n_fail++;
            $display("FAIL async_release: got ov=%b occ=%0d ir=%b required 0 0 1",
                     s_ov, s_occ, s_ir);
        end
    endtask

    task automatic test_n2();
        logic [W2-1:0] got0, got1;
        @(negedge clk);
        c_data = 16'hA55A;
        c_or = 1; c_iv = 1; c_sel = 1'b0;
        @(negedge clk);
        c_sel = 1'b1;
        got0 = c_od;
        @(negedge clk);
        c_iv = 0;
        got1 = c_od;
        n_tests++;
        if (got0 !== 8'h5A || got1 !== 8'hA5) begin
            n_fail++;
            $display("FAIL n2_select: got %h,%h required 5A,A5", got0, got1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_random();
        test_sel_err();
        test_async_reset();
        test_n2();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/mux_n_pipe.md
MUX_N_PIPE -- requirements
Module: mux_n_pipe

Interface
REQ-001 Parameter: WIDTH, 32, data width of every input channel and of the output.
REQ-002 Parameter: N, 4, number of input channels; legal range 2..16.
REQ-003 Parameter: SEL_W, $clog2(N) with a minimum of 1, width of sel.
REQ-004 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 Port: in_data  in  N*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port: sel  in  SEL_W  channel index for the current input beat.
REQ-008 Port: in_valid  in  1  input beat present.
REQ-009 Port: in_ready  out  1  block can accept a beat this cycle.
REQ-010 Port: out_data  out  WIDTH  selected, registered data.
REQ-011 Port: out_valid  out  1  out_data holds a valid beat.
REQ-012 Port: out_ready  in  1  downstream accepts out_data this cycle.
REQ-013 Port: flush  in  1  synchronous discard of all buffered beats.
REQ-014 Port: err_clr  in  1  synchronous clear of sel_err.
REQ-015 Port: sel_err  out  1  sticky flag: an out-of-range sel was accepted.
REQ-016 Port: occ  out  2  buffered beat count, 0..2.

Function
REQ-017 Accept occurs when in_valid && in_ready; fire occurs when out_valid && out_ready.
REQ-018 The accepted beat stores in_data channel sel; if sel >= N, the stored value is all zeros.
REQ-019 Latency is exactly 1 cycle: a beat accepted at edge t appears on out_data after edge t when the buffer was empty.
REQ-020 Storage is a 2-entry FIFO (head plus skid), so throughput is one beat per cycle with zero-bubble backpressure.
REQ-021 State EMPTY (occ=0) on accept goes to ONE; otherwise it stays EMPTY.
REQ-022 State ONE (occ=1) on accept with fire stays ONE and the head is replaced by the new beat.
REQ-023 State ONE on accept without fire goes to TWO and the new beat enters skid.
REQ-024 State ONE on fire without accept goes to EMPTY.
REQ-025 State TWO (occ=2) on fire goes to ONE and skid moves to head; it never accepts.
REQ-026 in_ready = (occ != 2) && !flush; it is combinational from the state and flush only, never from in_valid.
REQ-027 out_valid = (occ != 0); out_data is the head entry.
REQ-028 While out_valid && !out_ready, out_data stays stable until fire.
REQ-029 Beats leave in acceptance order; none are dropped or duplicated except by flush.
REQ-030 Flush has highest priority: on the next edge occ=0, both entries are discarded, and no beat is accepted in the flush cycle; a fire in that cycle still completes downstream.
REQ-031 sel_err sets on an accept with sel >= N and clears on err_clr; when set and clear coincide, set wins; flush does not affect sel_err.
REQ-032 With N=2 and no backpressure, sel=0 yields channel 0 and sel=1 yields channel 1, one cycle later.

Reset
REQ-033 While rst_n=0, asynchronously: occ=0, out_valid=0, out_data=0, sel_err=0, in_ready=0.
REQ-034 in_ready goes high on the first cycle after rst_n deasserts, absent flush.
REQ-035 Reset asserted mid-transfer discards all buffered beats; no partial beat appears after release.

Verification
REQ-036 N=4, WIDTH=32, channels 0x11/0x22/0x33/0x44, out_ready=1, sel=2 at t -> out_data=0x33 with out_valid=1 after t+1, occ=1.
REQ-037 Streaming sel 0,1,2,3 on back-to-back cycles with out_ready=1 -> 0x11,0x22,0x33,0x44 on consecutive cycles, in_ready constantly 1.
REQ-038 out_ready=0, push beats A then B -> occ=2, in_ready=0, out_data=A held; then out_ready=1 -> A, then B, occ returns to 0.
REQ-039 N=3 with sel=3 accepted -> out_data=0, sel_err=1 until err_clr; err_clr together with another sel=3 accept -> sel_err stays 1.
REQ-040 occ=2 plus flush -> next cycle occ=0, out_valid=0, and in_ready=1 one cycle after flush drops.
REQ-041 rst_n pulsed low asynchronously (between edges) at occ=2 -> out_valid=0, occ=0 immediately, sel_err=0.
